// File: rtl/dmem_port_arbiter_pkg.sv
// Shared state, owner encodings and arbitration rule for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int CNT_W = 3;

    // DMA takes the port when the CPU is not asking, or when the CPU has used up its allowance.
    function automatic logic dma_wins(input logic cpu_req, input logic dma_req, input logic starved);
        return ~cpu_req | (dma_req & starved);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a DMA master,
// sequencing each access through a fixed-latency memory and returning data with a one-cycle ack.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              stall_m_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e        state_q;
    logic              owner_q;
    logic              op_we_q;
    logic [CNT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              grant_dma_d;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              cpu_ack_q;
    logic              dma_ack_q;

    // Winner selection and starvation bookkeeping; only meaningful while IDLE.
    always_comb begin
        grant_dma_d = dma_wins(cpu_req_i, dma_req_i, starve_q == STARVE_LIM);
        starve_d    = starve_q;
        if (state_q == IDLE) begin
            if (!dma_req_i || grant_dma_d) begin
                starve_d = '0;
            end else if (cpu_req_i && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            op_we_q     <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_i || dma_req_i) begin
                        owner_q     <= grant_dma_d ? OWN_DMA : OWN_CPU;
                        op_we_q     <= grant_dma_d ? dma_we_i : cpu_we_i;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_dma_d ? dma_we_i : cpu_we_i;
                        mem_addr_q  <= grant_dma_d ? dma_addr_i : cpu_addr_i;
                        mem_wdata_q <= grant_dma_d ? dma_wdata_i : cpu_wdata_i;
                        lat_q       <= '0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The last ACCESS cycle is the one in which memory presents the read data.
                    if (lat_q == LAT_LAST) begin
                        if (!op_we_q) begin
                            if (owner_q == OWN_DMA) begin
                                dma_rdata_q <= mem_rdata_i;
                            end else begin
                                cpu_rdata_q <= mem_rdata_i;
                            end
                        end
                        state_q <= RESP;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                RESP: begin
                    if (owner_q == OWN_DMA) begin
                        dma_ack_q <= 1'b1;
                    end else begin
                        cpu_ack_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign dma_rdata_o = dma_rdata_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dma_ack_o   = dma_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Gated by rst so that every output reads 0 while reset is held.
    assign stall_m_o = rst & cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a latency-accurate memory, a transaction-level
// reference model with a shadow memory, a vector table, hand sequences and random rounds.
module tb_dmem_port_arbiter;

    localparam int L       = 2;
    localparam int SMAX    = 4;
    localparam int ACK_LAT = L + 3;
    localparam logic [31:0] JUNK = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, stall_m;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .stall_m_o(stall_m),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    // Initial memory contents: 0x10 holds 0xDEADBEEF, everything else an address-derived pattern.
    function automatic logic [31:0] defaultWord(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory environment: word-indexed store, read data delivered L cycles after the mem_en cycle.
    logic [31:0] envMem [256];
    bit          envSet [256];
    logic [31:0] stage  [0:L];

    function automatic logic [31:0] envRead(input logic [31:0] a);
        return envSet[a[9:2]] ? envMem[a[9:2]] : defaultWord(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        for (int i = L; i > 0; i--) stage[i] <= stage[i-1];
        stage[0] <= JUNK;
        if (mem_en) begin
            if (mem_we) begin
                envMem[mem_addr[9:2]] <= mem_wdata;
                envSet[mem_addr[9:2]] <= 1'b1;
            end else begin
                stage[0] <= envRead(mem_addr);
            end
        end
        if (mem_we) checkOutput("mem_we_needs_en", {31'b0, mem_en}, 32'd1);
    end

    assign mem_rdata = stage[L];

    // Reference shadow memory, updated only from the bench's own view of the transactions.
    logic [31:0] shadow    [256];
    bit          shadowSet [256];
    logic [31:0] prevC = '0;
    logic [31:0] prevD = '0;

    function automatic logic [31:0] shadowRead(input logic [31:0] a);
        return shadowSet[a[9:2]] ? shadow[a[9:2]] : defaultWord(a);
    endfunction

    task automatic shadowWrite(input logic [31:0] a, input logic [31:0] d);
        shadow[a[9:2]]    = d;
        shadowSet[a[9:2]] = 1'b1;
    endtask

    task automatic applyStimulus(input logic cR, input logic cW, input logic [31:0] cA, input logic [31:0] cD,
                                 input logic dR, input logic dW, input logic [31:0] dA, input logic [31:0] dD);
        cpu_req = cR; cpu_we = cW; cpu_addr = cA; cpu_wdata = cD;
        dma_req = dR; dma_we = dW; dma_addr = dA; dma_wdata = dD;
    endtask

    // One round from IDLE: requests issued together, each dropped on its own ack. CPU goes first.
    task automatic runRound(input string tag,
                            input logic cR, input logic cW, input logic [31:0] cA, input logic [31:0] cD,
                            input logic dR, input logic dW, input logic [31:0] dA, input logic [31:0] dD,
                            input logic [31:0] expC, input logic [31:0] expD);
        int expCCyc, expDCyc, lastCyc;
        int cAckAt = -1, dAckAt = -1, cAcks = 0, dAcks = 0, enCount = 0, enRight = 0;
        logic stallOk = 1'b1;
        expCCyc = cR ? ACK_LAT : -1;
        expDCyc = dR ? (cR ? 2 * ACK_LAT : ACK_LAT) : -1;
        lastCyc = ((cR && dR) ? 2 * ACK_LAT : ACK_LAT) + 3;
        applyStimulus(cR, cW, cA, cD, dR, dW, dA, dD);
        #1;
        checkOutput({tag, "_stall_c0"}, {31'b0, stall_m}, {31'b0, cR});
        for (int k = 1; k <= lastCyc; k++) begin
            @(negedge clk);
            if (stall_m !== (cR && (k < expCCyc))) stallOk = 1'b0;
            if (mem_en) begin
                enCount++;
                if (cR && k == expCCyc - L - 2) begin
                    enRight++;
                    checkOutput({tag, "_cpu_mem_addr"}, mem_addr, cA);
                    checkOutput({tag, "_cpu_mem_we"}, {31'b0, mem_we}, {31'b0, cW});
                    if (cW) checkOutput({tag, "_cpu_mem_wdata"}, mem_wdata, cD);
                end else if (dR && k == expDCyc - L - 2) begin
                    enRight++;
                    checkOutput({tag, "_dma_mem_addr"}, mem_addr, dA);
                    checkOutput({tag, "_dma_mem_we"}, {31'b0, mem_we}, {31'b0, dW});
                    if (dW) checkOutput({tag, "_dma_mem_wdata"}, mem_wdata, dD);
                end
            end
            if (cpu_ack) begin
                cAcks++;
                if (cAckAt < 0) cAckAt = k;
                checkOutput({tag, "_cpu_rdata_at_ack"}, cpu_rdata, expC);
                cpu_req = 1'b0;
            end
            if (dma_ack) begin
                dAcks++;
                if (dAckAt < 0) dAckAt = k;
                checkOutput({tag, "_dma_rdata_at_ack"}, dma_rdata, expD);
                dma_req = 1'b0;
            end
        end
        applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
        checkOutput({tag, "_cpu_ack_cycle"}, cAckAt, expCCyc);
        checkOutput({tag, "_dma_ack_cycle"}, dAckAt, expDCyc);
        checkOutput({tag, "_cpu_ack_count"}, cAcks, cR ? 1 : 0);
        checkOutput({tag, "_dma_ack_count"}, dAcks, dR ? 1 : 0);
        checkOutput({tag, "_mem_en_count"}, enCount, int'(cR) + int'(dR));
        checkOutput({tag, "_mem_en_timing"}, enRight, int'(cR) + int'(dR));
        checkOutput({tag, "_stall_profile"}, {31'b0, stallOk}, 32'd1);
        checkOutput({tag, "_cpu_rdata_end"}, cpu_rdata, expC);
        checkOutput({tag, "_dma_rdata_end"}, dma_rdata, expD);
    endtask

    typedef struct {
        logic        isDma;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'h5A5A_0040};
        vecs[4] = '{1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 32'h5A5A_0040};
        vecs[5] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h1234_5678};

        // Reset state.
        @(negedge clk);
        checkOutput("rst_mem_en", {31'b0, mem_en}, 0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_cpu_ack", {31'b0, cpu_ack}, 0);
        checkOutput("rst_dma_ack", {31'b0, dma_ack}, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        checkOutput("rst_dma_rdata", dma_rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Vector table: single-requester transactions.
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].isDma) begin
                runRound($sformatf("vec%0d", i), 0, 0, '0, '0,
                         1, vecs[i].we, vecs[i].addr, vecs[i].wdata, prevC, vecs[i].expRdata);
                prevD = vecs[i].expRdata;
            end else begin
                runRound($sformatf("vec%0d", i), 1, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                         0, 0, '0, '0, vecs[i].expRdata, prevD);
                prevC = vecs[i].expRdata;
            end
            if (vecs[i].we) shadowWrite(vecs[i].addr, vecs[i].wdata);
        end

        // Both requesters held high: CPU may win SMAX times in a row before DMA is forced in.
        begin
            int order[$];
            int ackAt[$];
            int expOrder [6] = '{0, 0, 0, 0, 1, 0};
            applyStimulus(1, 0, 32'h100, '0, 1, 0, 32'h200, '0);
            for (int k = 1; k <= 80 && order.size() < 6; k++) begin
                @(negedge clk);
                if (cpu_ack) begin
                    order.push_back(0); ackAt.push_back(k);
                    checkOutput("starve_cpu_rdata", cpu_rdata, shadowRead(32'h100));
                end
                if (dma_ack) begin
                    order.push_back(1); ackAt.push_back(k);
                    checkOutput("starve_dma_rdata", dma_rdata, shadowRead(32'h200));
                end
            end
            applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
            checkOutput("starve_ack_count", order.size(), 6);
            for (int i = 0; i < order.size() && i < 6; i++) begin
                checkOutput($sformatf("starve_grant%0d", i), order[i], expOrder[i]);
                checkOutput($sformatf("starve_ack_cycle%0d", i), ackAt[i], (i + 1) * ACK_LAT);
            end
            prevC = shadowRead(32'h100);
            prevD = shadowRead(32'h200);
            repeat (3) @(negedge clk);
        end

        // CPU keeps req high across its ack and presents a new address.
        begin
            int ack1 = -1, ack2 = -1, en2 = -1, oldEn = 0;
            applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
            for (int k = 1; k <= 40 && ack2 < 0; k++) begin
                @(negedge clk);
                if (mem_en) begin
                    if (mem_addr == 32'h10) oldEn++;
                    else if (mem_addr == 32'h20 && en2 < 0) en2 = k;
                end
                if (cpu_ack) begin
                    if (ack1 < 0) begin
                        ack1 = k;
                        checkOutput("hold_rdata1", cpu_rdata, shadowRead(32'h10));
                        cpu_addr = 32'h20;
                    end else begin
                        ack2 = k;
                        checkOutput("hold_rdata2", cpu_rdata, shadowRead(32'h20));
                        cpu_req = 1'b0;
                    end
                end
            end
            applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
            checkOutput("hold_ack1_cycle", ack1, ACK_LAT);
            checkOutput("hold_old_addr_accesses", oldEn, 1);
            checkOutput("hold_second_en_gap", en2 - ack1, 1);
            checkOutput("hold_ack2_gap", ack2 - ack1, ACK_LAT);
            prevC = shadowRead(32'h20);
            repeat (3) @(negedge clk);
        end

        // Reset in the second ACCESS cycle abandons the access; the held request is served again.
        begin
            int ackAt = -1, acks = 0;
            applyStimulus(1, 0, 32'h10, '0, 0, 0, '0, '0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkOutput("arst_mem_en", {31'b0, mem_en}, 0);
            checkOutput("arst_mem_we", {31'b0, mem_we}, 0);
            checkOutput("arst_mem_addr", mem_addr, 0);
            checkOutput("arst_cpu_ack", {31'b0, cpu_ack}, 0);
            checkOutput("arst_cpu_rdata", cpu_rdata, 0);
            checkOutput("arst_dma_rdata", dma_rdata, 0);
            checkOutput("arst_stall", {31'b0, stall_m}, 0);
            @(negedge clk);
            checkOutput("arst_no_ack", {31'b0, cpu_ack}, 0);
            rst = 1'b1;
            for (int k = 1; k <= ACK_LAT + 3; k++) begin
                @(negedge clk);
                if (cpu_ack) begin
                    acks++;
                    if (ackAt < 0) ackAt = k;
                    checkOutput("arst_reserve_rdata", cpu_rdata, shadowRead(32'h10));
                    cpu_req = 1'b0;
                end
            end
            applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
            checkOutput("arst_reserve_ack_cycle", ackAt, ACK_LAT);
            checkOutput("arst_reserve_ack_count", acks, 1);
            prevC = shadowRead(32'h10);
            prevD = '0;
            repeat (2) @(negedge clk);
        end

        // Random rounds against the transaction-level model.
        for (int r = 0; r < 40; r++) begin
            int sel;
            logic cR, dR, cW, dW;
            logic [31:0] cA, dA, cD, dD, expC, expD;
            sel = $urandom_range(0, 2);
            cR  = (sel != 1);
            dR  = (sel != 0);
            cW  = 1'($urandom_range(0, 1));
            dW  = 1'($urandom_range(0, 1));
            cA  = 32'h300 + ($urandom_range(0, 7) << 2);
            dA  = 32'h300 + ($urandom_range(0, 7) << 2);
            cD  = $urandom;
            dD  = $urandom;
            expC = prevC;
            expD = prevD;
            if (cR) begin
                if (cW) shadowWrite(cA, cD);
                else    expC = shadowRead(cA);
            end
            if (dR) begin
                if (dW) shadowWrite(dA, dD);
                else    expD = shadowRead(dA);
            end
            runRound($sformatf("rnd%0d", r), cR, cW, cA, cD, dR, dW, dA, dD, expC, expD);
            prevC = expC;
            prevD = expD;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
